// File: rtl/fu_operand_stage.sv
// ---------------------------------------------------------------------------
// fu_operand_stage
//
// Operand/issue stage that sits directly in front of the functional unit (FU)
// and also acts as the write-back sink for the FU result.
//
// The stage holds the register file. It issues at most one op per cycle as
// registered A/B/control_signals. On the following edge it writes the FU's
// combinational result (F) and flags (status_signals) back. A read-after-write
// hazard against the op currently in flight is handled in one of two ways:
//
//   FU_FWD_EN defined   : F is forwarded into the operand mux, and the stage
//                         never stalls.
//   FU_FWD_EN undefined : in_ready drops for one cycle, a bubble is issued,
//                         and the dependent op then reads the updated RF.
//
// Configuration macro: FU_FWD_EN (default build: undefined, stall on hazard).
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   op request handshake; in_ready ignores in_valid
//   in_ra, in_rb, in_rd   source A, source B and destination registers
//   in_ctrl               FU control word, passed through unchanged
//   in_use_imm, in_imm    select the immediate instead of RF[in_rb] for B
//   A, B, control_signals registered operands and control word to the FU
//   F, status_signals     combinational FU result and flags
//   wb_valid, wb_rd       write-back of F into RF[wb_rd] at the next edge
//   flags                 status_signals of the last written-back op
// ---------------------------------------------------------------------------
module fu_operand_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 6,
    parameter int unsigned STAT_W = 6
) (
    input  logic              clk,
    input  logic              reset,

    // Op request
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_ra,
    input  logic [ADDR_W-1:0] in_rb,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_use_imm,
    input  logic [DATA_W-1:0] in_imm,

    // Issue to FU
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic [CTRL_W-1:0] control_signals,

    // FU result
    input  logic [DATA_W-1:0] F,
    input  logic [STAT_W-1:0] status_signals,

    // Write-back visibility
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_rd,
    output logic [STAT_W-1:0] flags
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_W;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic              iss_valid_q, iss_valid_d;
    logic [ADDR_W-1:0] iss_rd_q,    iss_rd_d;
    logic [DATA_W-1:0] a_q,         a_d;
    logic [DATA_W-1:0] b_q,         b_d;
    logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
    logic [STAT_W-1:0] flags_q,     flags_d;

    // -----------------------------------------------------------------------
    // Operand read and hazard detection
    // -----------------------------------------------------------------------
    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              inflight_dst;
    logic              haz_a;
    logic              haz_b;
    logic              accept;
    logic              rf_we;

    always_comb begin
        // Register 0 is hard-wired to zero regardless of array contents.
        rf_a = (in_ra == '0) ? '0 : rf_q[in_ra];
        rf_b = (in_rb == '0) ? '0 : rf_q[in_rb];

        // Only an in-flight op with a real destination can create a hazard;
        // B never hazards when it is taken from the immediate.
        inflight_dst = iss_valid_q && (iss_rd_q != '0);
        haz_a        = inflight_dst && (iss_rd_q == in_ra);
        haz_b        = inflight_dst && !in_use_imm && (iss_rd_q == in_rb);

`ifdef FU_FWD_EN
        // The in-flight result is being written this very edge, so the RF
        // still holds the stale value; take it straight from the FU instead.
        op_a     = haz_a ? F : rf_a;
        op_b     = haz_b ? F : rf_b;
        in_ready = !reset;
`else
        // Hold the dependent op off for one cycle; by then the write-back
        // has landed in the RF and the plain read is correct.
        op_a     = rf_a;
        op_b     = rf_b;
        in_ready = !reset && !(haz_a || haz_b);
`endif

        accept = in_valid && in_ready;
        rf_we  = iss_valid_q && (iss_rd_q != '0);
    end

    // -----------------------------------------------------------------------
    // Next-state
    // -----------------------------------------------------------------------
    always_comb begin
        iss_valid_d = accept;
        iss_rd_d    = iss_rd_q;
        a_d         = a_q;
        b_d         = b_q;
        // A bubble carries a zero control word so the FU sees a quiet op.
        ctrl_d      = '0;
        flags_d     = flags_q;

        if (accept) begin
            iss_rd_d = in_rd;
            a_d      = op_a;
            b_d      = in_use_imm ? in_imm : op_b;
            ctrl_d   = in_ctrl;
        end

        if (iss_valid_q) begin
            flags_d = status_signals;
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            // Any op in flight is dropped: neither RF nor flags are written.
            iss_valid_q <= 1'b0;
            iss_rd_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            ctrl_q      <= '0;
            flags_q     <= '0;
            rf_q        <= '{default: '0};
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_rd_q    <= iss_rd_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctrl_q      <= ctrl_d;
            flags_q     <= flags_d;
            if (rf_we) begin
                rf_q[iss_rd_q] <= F;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign A               = a_q;
    assign B               = b_q;
    assign control_signals = ctrl_q;
    assign wb_valid        = iss_valid_q;
    assign wb_rd           = iss_rd_q;
    assign flags           = flags_q;

endmodule

// File: tb/tb_fu_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_fu_operand_stage
//
// Drives fu_operand_stage with a behavioural FU hung off its A/B outputs.
// The reference model treats the stage as a sequential machine: each accepted
// op reads the architectural register file as left by every earlier accepted
// op. Issue and write-back timing are then laid on top of that.
// ---------------------------------------------------------------------------
module tb_fu_operand_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CTRL_W = 6;
    localparam int unsigned STAT_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_ra;
    logic [ADDR_W-1:0] in_rb;
    logic [ADDR_W-1:0] in_rd;
    logic [CTRL_W-1:0] in_ctrl;
    logic              in_use_imm;
    logic [DATA_W-1:0] in_imm;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic [CTRL_W-1:0] control_signals;
    logic [DATA_W-1:0] F;
    logic [STAT_W-1:0] status_signals;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_rd;
    logic [STAT_W-1:0] flags;

    always #5 clk = ~clk;

    fu_operand_stage #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CTRL_W(CTRL_W),
        .STAT_W(STAT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_ra          (in_ra),
        .in_rb          (in_rb),
        .in_rd          (in_rd),
        .in_ctrl        (in_ctrl),
        .in_use_imm     (in_use_imm),
        .in_imm         (in_imm),
        .A              (A),
        .B              (B),
        .control_signals(control_signals),
        .F              (F),
        .status_signals (status_signals),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .flags          (flags)
    );

    // FU: ctrl[2:0] 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 pass B, else add.
    // Flags {N,V,C,Z,LT,ULT}.
    function automatic logic [STAT_W+DATA_W-1:0] fu_ref(input logic [31:0] a,
                                                        input logic [31:0] b,
                                                        input logic [5:0]  ctrl);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (ctrl[2:0])
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0];
                c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = b;
            default: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
        endcase
        return {r[31], v, c, (r == 32'd0), ($signed(a) < $signed(b)), (a < b), r};
    endfunction

    assign {status_signals, F} = fu_ref(A, B, control_signals);

    // -----------------------------------------------------------------------
    // Reference model
    // -----------------------------------------------------------------------
    logic [31:0] arch_rf [32];
    logic        m_valid;
    logic [4:0]  m_rd;
    logic [31:0] m_a;
    logic [31:0] m_b;
    logic [5:0]  m_ctrl;
    logic [5:0]  m_stat;
    logic [5:0]  m_flags;
    logic        last_acc;
    logic        started = 1'b0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    function automatic logic [31:0] arch_rd(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : arch_rf[r];
    endfunction

    function automatic logic model_ready();
        if (reset) return 1'b0;
`ifdef FU_FWD_EN
        return 1'b1;
`else
        return !(m_valid && m_rd != 5'd0 &&
                 (m_rd == in_ra || (!in_use_imm && m_rd == in_rb)));
`endif
    endfunction

    task automatic model_edge();
        logic                     acc;
        logic [31:0]              a;
        logic [31:0]              b;
        logic [STAT_W+DATA_W-1:0] res;
        started = 1'b1;
        if (reset) begin
            for (int i = 0; i < 32; i++) arch_rf[i] = 32'd0;
            m_valid  = 1'b0;
            m_rd     = 5'd0;
            m_a      = 32'd0;
            m_b      = 32'd0;
            m_ctrl   = 6'd0;
            m_stat   = 6'd0;
            m_flags  = 6'd0;
            last_acc = 1'b0;
        end else begin
            acc = in_valid && model_ready();
            if (m_valid) m_flags = m_stat;
            if (acc) begin
                a   = arch_rd(in_ra);
                b   = in_use_imm ? in_imm : arch_rd(in_rb);
                res = fu_ref(a, b, in_ctrl);
                if (in_rd != 5'd0) arch_rf[in_rd] = res[31:0];
                m_valid = 1'b1;
                m_rd    = in_rd;
                m_a     = a;
                m_b     = b;
                m_ctrl  = in_ctrl;
                m_stat  = res[37:32];
            end else begin
                m_valid = 1'b0;
                m_ctrl  = 6'd0;
            end
            last_acc = acc;
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", 64'(in_ready), 64'(model_ready()));
            chk("wb_valid", 64'(wb_valid), 64'(m_valid));
            if (m_valid) chk("wb_rd", 64'(wb_rd), 64'(m_rd));
            chk("A", 64'(A), 64'(m_a));
            chk("B", 64'(B), 64'(m_b));
            chk("control_signals", 64'(control_signals), 64'(m_ctrl));
            chk("flags", 64'(flags), 64'(m_flags));
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers
    // -----------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic issue_op(input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rd,
                            input logic [5:0] ctrl, input logic use_imm,
                            input logic [31:0] imm, output int cycles);
        in_valid   = 1'b1;
        in_ra      = ra;
        in_rb      = rb;
        in_rd      = rd;
        in_ctrl    = ctrl;
        in_use_imm = use_imm;
        in_imm     = imm;
        cycles     = 0;
        do begin
            tick();
            cycles++;
        end while (!last_acc && cycles < 8);
        if (!last_acc) begin
            n_vec++;
            n_err++;
            $display("FAIL issue bound: no accept after %0d cycles, required within 8", cycles);
        end
        in_valid = 1'b0;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 4) != 0) return 5'($urandom_range(0, 7));
        return 5'($urandom_range(0, 31));
    endfunction

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        int   cyc;
        int   exp_cyc;
        logic exp_rdy;
`ifdef FU_FWD_EN
        exp_cyc = 1;
        exp_rdy = 1'b1;
`else
        exp_cyc = 2;
        exp_rdy = 1'b0;
`endif
        reset      = 1'b1;
        in_valid   = 1'b0;
        in_ra      = '0;
        in_rb      = '0;
        in_rd      = '0;
        in_ctrl    = '0;
        in_use_imm = 1'b0;
        in_imm     = '0;
        tick();
        tick();
        reset = 1'b0;

        // 1. Preload, then a one-cycle reset clears everything.
        for (int r = 1; r <= 5; r++) begin
            issue_op(5'd0, 5'd0, 5'(r), 6'd0, 1'b1, 32'(r * 11 + 1), cyc);
        end
        idle(2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset flags", 64'(flags), 64'd0);
        chk("reset A", 64'(A), 64'd0);
        chk("reset B", 64'(B), 64'd0);
        chk("reset ctrl", 64'(control_signals), 64'd0);
        chk("reset wb_valid", 64'(wb_valid), 64'd0);
        for (int r = 1; r < 32; r++) begin
            issue_op(5'(r), 5'(r), 5'd0, 6'd0, 1'b0, 32'd0, cyc);
            chk("reset rf sweep", 64'(A), 64'd0);
        end
        idle(1);

        // 2. r1=5, r2=7, r3=r1+r2 with idle gaps.
        issue_op(5'd0, 5'd0, 5'd1, 6'd0, 1'b1, 32'd5, cyc);
        idle(2);
        issue_op(5'd0, 5'd0, 5'd2, 6'd0, 1'b1, 32'd7, cyc);
        idle(2);
        issue_op(5'd1, 5'd2, 5'd3, 6'd0, 1'b0, 32'd0, cyc);
        chk("add A", 64'(A), 64'd5);
        chk("add B", 64'(B), 64'd7);
        idle(2);
        chk("add flags", 64'(flags), 64'b000011);
        chk("model r3", 64'(arch_rf[3]), 64'd12);
        issue_op(5'd3, 5'd0, 5'd0, 6'd0, 1'b1, 32'd0, cyc);
        chk("read r3", 64'(A), 64'd12);
        idle(1);

        // 3. Back-to-back dependent: r1=FFFFFFFF, r2=r1+1.
        issue_op(5'd0, 5'd0, 5'd1, 6'd0, 1'b1, 32'hFFFF_FFFF, cyc);
        in_ra      = 5'd1;
        in_rb      = 5'd0;
        in_use_imm = 1'b1;
        #1;
        chk("dep in_ready", 64'(in_ready), 64'(exp_rdy));
        issue_op(5'd1, 5'd0, 5'd2, 6'd0, 1'b1, 32'd1, cyc);
        chk("dep issue cycles", 64'(cyc), 64'(exp_cyc));
        chk("dep A", 64'(A), 64'hFFFF_FFFF);
        idle(2);
        chk("carry flags", 64'(flags), 64'b001110);
        issue_op(5'd2, 5'd0, 5'd0, 6'd0, 1'b1, 32'd0, cyc);
        chk("read r2", 64'(A), 64'd0);
        idle(1);

        // 4. r0 ignores writes and never hazards.
        issue_op(5'd0, 5'd0, 5'd0, 6'd0, 1'b1, 32'd9, cyc);
        issue_op(5'd0, 5'd0, 5'd5, 6'd0, 1'b0, 32'd0, cyc);
        chk("r0 issue cycles", 64'(cyc), 64'd1);
        chk("r0 A", 64'(A), 64'd0);
        idle(2);

        // 5. Reset the cycle after accepting r4=3: the write is dropped.
        issue_op(5'd0, 5'd0, 5'd4, 6'd0, 1'b1, 32'd3, cyc);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("discard flags", 64'(flags), 64'd0);
        issue_op(5'd4, 5'd0, 5'd0, 6'd0, 1'b1, 32'd0, cyc);
        chk("discard r4", 64'(A), 64'd0);
        idle(1);

        // 6. Three idle cycles between ops: operands hold, control is zero.
        issue_op(5'd0, 5'd0, 5'd6, 6'd0, 1'b1, 32'h55, cyc);
        idle(3);
        chk("gap A", 64'(A), 64'd0);
        chk("gap B", 64'(B), 64'h55);
        chk("gap ctrl", 64'(control_signals), 64'd0);
        chk("gap wb_valid", 64'(wb_valid), 64'd0);
        chk("gap flags", 64'(flags), 64'b000011);
        issue_op(5'd6, 5'd6, 5'd7, 6'd1, 1'b0, 32'd0, cyc);
        idle(2);

        // Random traffic with dense register reuse.
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 199) == 0);
            in_valid   = ($urandom_range(0, 9) < 7);
            in_ra      = rnd_addr();
            in_rb      = rnd_addr();
            in_rd      = rnd_addr();
            in_ctrl    = 6'($urandom_range(0, 63));
            in_use_imm = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 3))
                0:       in_imm = 32'hFFFF_FFFF;
                1:       in_imm = 32'($urandom_range(0, 3));
                default: in_imm = $urandom();
            endcase
            tick();
        end
        reset = 1'b0;
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
